// File: rtl/card_corner_locator.sv
// Scans outward from a centre point in a thresholded frame to find the four card edges,
// then derives the top-left glyph window (address, width, height) for the classifier.
module card_corner_locator #(
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        find_corners_flag,
    input  logic [7:0]  x_center,
    input  logic [8:0]  y_center,
    input  logic [15:0] pixel_data_in,
    output logic [16:0] pixel_addr_out,
    output logic [7:0]  right_edge,
    output logic [7:0]  left_edge,
    output logic [8:0]  top_edge,
    output logic [8:0]  bot_edge,
    output logic        edges_valid,
    output logic [16:0] corner_addr_out,
    output logic [7:0]  corner_width,
    output logic [8:0]  corner_height,
    output logic        corner_valid
);

    localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SCAN_R = 3'd1;
    localparam logic [2:0] SCAN_L = 3'd2;
    localparam logic [2:0] SCAN_U = 3'd3;
    localparam logic [2:0] SCAN_D = 3'd4;
    localparam logic [2:0] CORNER = 3'd5;

    logic [2:0]    state;
    logic          launch;
    logic [CW-1:0] cnt;
    logic [7:0]    xc;
    logic [7:0]    pos_x;
    logic [8:0]    yc;
    logic [8:0]    pos_y;
    logic          probe_done;
    logic          card;
    logic [7:0]    span_x;
    logic [8:0]    span_y;

    // Start is a single-cycle pulse, honoured only in IDLE; results are qualified by
    // one-cycle edges_valid then corner_valid pulses and hold until the next run.
    assign probe_done = !launch && (cnt == LAT);
    assign card       = pixel_data_in != 16'd0;
    assign span_x     = right_edge - left_edge;
    assign span_y     = bot_edge - top_edge;

    function automatic logic [16:0] pix_addr(input logic [8:0] y, input logic [7:0] x);
        return 17'(int'(y) * WIDTH) + 17'(x);
    endfunction

    // launch marks the first cycle of a scan: either issue the first probe or, at the
    // image border, finish immediately without touching the RAM.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            launch          <= 1'b0;
            cnt             <= '0;
            xc              <= '0;
            yc              <= '0;
            pos_x           <= '0;
            pos_y           <= '0;
            pixel_addr_out  <= '0;
            right_edge      <= '0;
            left_edge       <= '0;
            top_edge        <= '0;
            bot_edge        <= '0;
            edges_valid     <= 1'b0;
            corner_addr_out <= '0;
            corner_width    <= '0;
            corner_height   <= '0;
            corner_valid    <= 1'b0;
        end else begin
            edges_valid  <= 1'b0;
            corner_valid <= 1'b0;
            if (!launch && cnt != LAT) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (find_corners_flag) begin
                        xc     <= x_center;
                        yc     <= y_center;
                        state  <= SCAN_R;
                        launch <= 1'b1;
                    end
                end
                SCAN_R: begin
                    if (launch) begin
                        if (xc == X_MAX) begin
                            right_edge <= xc;
                            state      <= SCAN_L;
                        end else begin
                            pos_x          <= xc + 8'd1;
                            pixel_addr_out <= pix_addr(yc, xc + 8'd1);
                            launch         <= 1'b0;
                            cnt            <= '0;
                        end
                    end else if (probe_done) begin
                        if (!card || pos_x == X_MAX) begin
                            right_edge <= card ? pos_x : pos_x - 8'd1;
                            state      <= SCAN_L;
                            launch     <= 1'b1;
                        end else begin
                            pos_x          <= pos_x + 8'd1;
                            pixel_addr_out <= pix_addr(yc, pos_x + 8'd1);
                            cnt            <= '0;
                        end
                    end
                end
                SCAN_L: begin
                    if (launch) begin
                        if (xc == 8'd0) begin
                            left_edge <= xc;
                            state     <= SCAN_U;
                        end else begin
                            pos_x          <= xc - 8'd1;
                            pixel_addr_out <= pix_addr(yc, xc - 8'd1);
                            launch         <= 1'b0;
                            cnt            <= '0;
                        end
                    end else if (probe_done) begin
                        if (!card || pos_x == 8'd0) begin
                            left_edge <= card ? pos_x : pos_x + 8'd1;
                            state     <= SCAN_U;
                            launch    <= 1'b1;
                        end else begin
                            pos_x          <= pos_x - 8'd1;
                            pixel_addr_out <= pix_addr(yc, pos_x - 8'd1);
                            cnt            <= '0;
                        end
                    end
                end
                SCAN_U: begin
                    if (launch) begin
                        if (yc == 9'd0) begin
                            top_edge <= yc;
                            state    <= SCAN_D;
                        end else begin
                            pos_y          <= yc - 9'd1;
                            pixel_addr_out <= pix_addr(yc - 9'd1, xc);
                            launch         <= 1'b0;
                            cnt            <= '0;
                        end
                    end else if (probe_done) begin
                        if (!card || pos_y == 9'd0) begin
                            top_edge <= card ? pos_y : pos_y + 9'd1;
                            state    <= SCAN_D;
                            launch   <= 1'b1;
                        end else begin
                            pos_y          <= pos_y - 9'd1;
                            pixel_addr_out <= pix_addr(pos_y - 9'd1, xc);
                            cnt            <= '0;
                        end
                    end
                end
                SCAN_D: begin
                    if (launch) begin
                        if (yc == Y_MAX) begin
                            bot_edge    <= yc;
                            state       <= CORNER;
                            launch      <= 1'b0;
                            edges_valid <= 1'b1;
                        end else begin
                            pos_y          <= yc + 9'd1;
                            pixel_addr_out <= pix_addr(yc + 9'd1, xc);
                            launch         <= 1'b0;
                            cnt            <= '0;
                        end
                    end else if (probe_done) begin
                        if (!card || pos_y == Y_MAX) begin
                            bot_edge    <= card ? pos_y : pos_y - 9'd1;
                            state       <= CORNER;
                            edges_valid <= 1'b1;
                        end else begin
                            pos_y          <= pos_y + 9'd1;
                            pixel_addr_out <= pix_addr(pos_y + 9'd1, xc);
                            cnt            <= '0;
                        end
                    end
                end
                CORNER: begin
                    corner_addr_out <= pix_addr(top_edge, left_edge);
                    corner_width    <= span_x >> 2;
                    corner_height   <= span_y >> 2;
                    corner_valid    <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    launch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_corner_locator.sv
// Bench for card_corner_locator: frame RAM model, edge-scan reference model, scoreboard
// of expected results, directed scenarios plus randomized card images and centres.
module tb_card_corner_locator;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        find_corners_flag;
    logic [7:0]  x_center;
    logic [8:0]  y_center;
    logic [15:0] pixel_data_in;
    logic [16:0] pixel_addr_out;
    logic [7:0]  right_edge, left_edge;
    logic [8:0]  top_edge, bot_edge;
    logic        edges_valid;
    logic [16:0] corner_addr_out;
    logic [7:0]  corner_width;
    logic [8:0]  corner_height;
    logic        corner_valid;

    always #5 clk_in = ~clk_in;

    card_corner_locator dut (
        .clk_in(clk_in), .rst_in(rst_in), .find_corners_flag(find_corners_flag),
        .x_center(x_center), .y_center(y_center), .pixel_data_in(pixel_data_in),
        .pixel_addr_out(pixel_addr_out), .right_edge(right_edge), .left_edge(left_edge),
        .top_edge(top_edge), .bot_edge(bot_edge), .edges_valid(edges_valid),
        .corner_addr_out(corner_addr_out), .corner_width(corner_width),
        .corner_height(corner_height), .corner_valid(corner_valid)
    );

    // Frame RAM: registered address then one-cycle read.
    logic [15:0] mem [0:76799];
    logic [16:0] addr_q = '0;
    always @(posedge clk_in) begin
        addr_q        <= pixel_addr_out;
        pixel_data_in <= (addr_q < 17'd76800) ? mem[int'(addr_q)] : 16'h0000;
    end

    int total = 0;
    int bad = 0;
    int ev_count = 0;
    int cv_count = 0;
    bit prev_ev = 1'b0;
    logic [67:0] exp_q[$];

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    function automatic int pix(input int x, input int y);
        return (mem[y * 240 + x] != 16'h0000) ? 1 : 0;
    endfunction

    // Reference: walk outward from the centre until the card ends or the frame ends.
    function automatic logic [67:0] model(input int xc, input int yc);
        int r, l, t, b, a, w, h;
        r = xc; while (r < 239 && pix(r + 1, yc) == 1) r++;
        l = xc; while (l > 0 && pix(l - 1, yc) == 1) l--;
        t = yc; while (t > 0 && pix(xc, t - 1) == 1) t--;
        b = yc; while (b < 319 && pix(xc, b + 1) == 1) b++;
        a = (t * 240 + l) % 131072;
        w = (r - l) / 4;
        h = (b - t) / 4;
        return {8'(r), 8'(l), 9'(t), 9'(b), 17'(a), 8'(w), 9'(h)};
    endfunction

    // Scoreboard: edges checked on edges_valid, corners on corner_valid (then popped).
    always @(negedge clk_in) begin
        logic [67:0] e;
        if (pixel_addr_out > 17'd76799) check("addr_range", int'(pixel_addr_out), 76799);
        if (rst_in) begin
            prev_ev = 1'b0;
        end else begin
            if (edges_valid) begin
                ev_count++;
                check("ev_one_cycle", int'(prev_ev), 0);
                if (exp_q.size() == 0) check("spurious_edges_valid", 1, 0);
                else begin
                    e = exp_q[0];
                    check("right_edge", int'(right_edge), int'(e[67:60]));
                    check("left_edge", int'(left_edge), int'(e[59:52]));
                    check("top_edge", int'(top_edge), int'(e[51:43]));
                    check("bot_edge", int'(bot_edge), int'(e[42:34]));
                end
            end
            if (corner_valid) begin
                cv_count++;
                check("cv_after_ev", int'(prev_ev), 1);
                if (exp_q.size() == 0) check("spurious_corner_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("corner_addr", int'(corner_addr_out), int'(e[33:17]));
                    check("corner_width", int'(corner_width), int'(e[16:9]));
                    check("corner_height", int'(corner_height), int'(e[8:0]));
                end
            end
            prev_ev = edges_valid;
        end
    end

    task automatic fill(input int x0, input int x1, input int y0, input int y1, input int holes);
        for (int a = 0; a < 76800; a++) begin
            int x, y;
            x = a % 240;
            y = a / 240;
            mem[a] = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 16'($urandom_range(1, 65535)) : 16'h0000;
        end
        for (int k = 0; k < holes; k++)
            mem[$urandom_range(y0, y1) * 240 + $urandom_range(x0, x1)] = 16'h0000;
    endtask

    task automatic start(input int xc, input int yc);
        @(posedge clk_in); #1;
        x_center = 8'(xc);
        y_center = 9'(yc);
        find_corners_flag = 1'b1;
        @(posedge clk_in); #1;
        find_corners_flag = 1'b0;
    endtask

    task automatic wait_done();
        int c0;
        bit done;
        c0 = cv_count;
        done = 1'b0;
        for (int n = 0; n < 5000 && !done; n++) begin
            @(posedge clk_in);
            if (cv_count > c0) done = 1'b1;
        end
        if (!done) begin
            check("run_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic run(input int xc, input int yc);
        exp_q.push_back(model(xc, yc));
        start(xc, yc);
        wait_done();
    endtask

    task automatic wait_addr(input int a, input int limit);
        bit found;
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk_in);
            if (int'(pixel_addr_out) == a) found = 1'b1;
        end
        if (!found) check("wait_addr", int'(pixel_addr_out), a);
    endtask

    task automatic check_outs(input string tag, input int r, input int l, input int t, input int b,
                              input int a, input int w, input int h);
        @(negedge clk_in);
        check({tag, "_right"}, int'(right_edge), r);
        check({tag, "_left"}, int'(left_edge), l);
        check({tag, "_top"}, int'(top_edge), t);
        check({tag, "_bot"}, int'(bot_edge), b);
        check({tag, "_caddr"}, int'(corner_addr_out), a);
        check({tag, "_cw"}, int'(corner_width), w);
        check({tag, "_ch"}, int'(corner_height), h);
    endtask

    initial begin
        int chg_v[$];
        int chg_t[$];
        int prev_a, c_ev, c_cv;

        rst_in = 1'b1;
        find_corners_flag = 1'b0;
        x_center = '0;
        y_center = '0;
        fill(0, -1, 0, -1, 0);
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset_addr", int'(pixel_addr_out), 0);
        check("reset_valids", int'({edges_valid, corner_valid}), 0);

        // Rectangle card; also watch the first right-scan probes.
        fill(40, 190, 30, 280, 0);
        exp_q.push_back(model(114, 153));
        start(114, 153);
        prev_a = int'(pixel_addr_out);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            if (int'(pixel_addr_out) != prev_a) begin
                chg_v.push_back(int'(pixel_addr_out));
                chg_t.push_back(c);
                prev_a = int'(pixel_addr_out);
            end
        end
        check("probe_count", (chg_v.size() >= 6) ? 1 : 0, 1);
        if (chg_v.size() >= 6) begin
            check("first_probe_addr", chg_v[0], 36835);
            for (int k = 1; k < 6; k++) begin
                check("probe_step", chg_v[k], 36835 + k);
                check("probe_hold", chg_t[k] - chg_t[k-1], 3);
            end
        end
        wait_done();
        repeat (4) @(posedge clk_in);
        check_outs("rect", 190, 40, 30, 280, 7240, 37, 62);

        // Whole-frame card, centre inside and at frame corners.
        fill(0, 239, 0, 319, 0);
        run(114, 153);
        check_outs("full", 239, 0, 0, 319, 0, 59, 79);
        run(239, 319);
        check_outs("full_br", 239, 0, 0, 319, 0, 59, 79);
        run(0, 0);

        // Background centre with background neighbours.
        fill(0, -1, 0, -1, 0);
        run(10, 10);
        check_outs("bg", 10, 10, 10, 10, 2410, 0, 0);

        // Reset during the upward scan aborts the run.
        fill(40, 190, 30, 280, 0);
        start(114, 153);
        wait_addr(152 * 240 + 114, 2000);
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        check_outs("midreset", 0, 0, 0, 0, 0, 0, 0);
        check("midreset_valids", int'({edges_valid, corner_valid}), 0);
        c_ev = ev_count;
        repeat (1500) @(posedge clk_in);
        check("midreset_no_pulse", ev_count - c_ev, 0);
        run(114, 153);
        check_outs("after_reset", 190, 40, 30, 280, 7240, 37, 62);

        // Second start during the left scan must be ignored.
        c_ev = ev_count;
        c_cv = cv_count;
        exp_q.push_back(model(114, 153));
        start(114, 153);
        wait_addr(153 * 240 + 113, 2000);
        @(posedge clk_in); #1;
        x_center = 8'd20;
        y_center = 9'd20;
        find_corners_flag = 1'b1;
        @(posedge clk_in); #1 find_corners_flag = 1'b0;
        wait_done();
        repeat (40) @(posedge clk_in);
        check("busy_start_ev", ev_count - c_ev, 1);
        check("busy_start_cv", cv_count - c_cv, 1);

        // Randomized cards with holes and centres.
        for (int t = 0; t < 12; t++) begin
            int x0, x1, y0, y1, xc, yc;
            x0 = $urandom_range(0, 120);
            x1 = $urandom_range(x0, 239);
            y0 = $urandom_range(0, 160);
            y1 = $urandom_range(y0, 319);
            if ($urandom_range(0, 3) == 0) begin x0 = 0; x1 = 239; end
            if ($urandom_range(0, 3) == 0) begin y0 = 0; y1 = 319; end
            fill(x0, x1, y0, y1, $urandom_range(0, 40));
            if ($urandom_range(0, 3) != 0) begin
                xc = $urandom_range(x0, x1);
                yc = $urandom_range(y0, y1);
            end else begin
                xc = $urandom_range(0, 239);
                yc = $urandom_range(0, 319);
            end
            run(xc, yc);
        end

        repeat (5) @(posedge clk_in);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/card_corner_locator.md
Name: card_corner_locator

Overview:
- Locates the four edges of a playing card in a thresholded 240x320 frame held in an external single-port RAM.
- Scans outward from a supplied centre point along its row and its column until the card ends in each direction.
- Derives the top-left corner window (start address, width, height) where the rank/suit glyph sits.
- Sits between the threshold/frame-buffer stage and the rank/suit classifier.

Parameters:
- WIDTH, 240, frame width in pixels.
- HEIGHT, 320, frame height in pixels.
- READ_LATENCY, 2, cycles from pixel_addr_out change to the matching pixel_data_in (external RAM: registered address plus 1-cycle read).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- find_corners_flag  input  1  one-cycle start pulse
- x_center  input  8  scan centre column
- y_center  input  9  scan centre row
- pixel_data_in  input  16  RAM read data; nonzero = card pixel
- pixel_addr_out  output  17  RAM read address, y*WIDTH+x
- right_edge  output  8  last card column right of centre
- left_edge  output  8  last card column left of centre
- top_edge  output  9  last card row above centre
- bot_edge  output  9  last card row below centre
- edges_valid  output  1  one-cycle pulse; edges final
- corner_addr_out  output  17  top_edge*WIDTH+left_edge
- corner_width  output  8  (right_edge-left_edge)>>2
- corner_height  output  9  (bot_edge-top_edge)>>2
- corner_valid  output  1  one-cycle pulse; corner outputs final

Behaviour:
- Clock and reset: one clock domain, clk_in. rst_in is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE. A reset mid-scan aborts the scan, returns to IDLE and clears all outputs; no valid pulse is produced.
- FSM states: IDLE -> SCAN_R -> SCAN_L -> SCAN_U -> SCAN_D -> CORNER -> IDLE.
- Start: find_corners_flag is sampled only in IDLE. It latches x_center and y_center, then enters SCAN_R. Start pulses while busy are ignored.
- Probe timing: each probe drives pixel_addr_out, waits READ_LATENCY cycles, then tests pixel_data_in != 0. A probe therefore takes READ_LATENCY+1 cycles. Between probes, pixel_addr_out holds its last value.
- SCAN_R: probes x = xc+1, xc+2, ... on row yc.
  - On the first non-card pixel at x: right_edge = x-1.
  - If x = WIDTH-1 is still card, right_edge = WIDTH-1 and the scan stops.
  - If xc = WIDTH-1 at start, no probe is issued and right_edge = xc.
- SCAN_L: mirror of SCAN_R, decrementing x. Image boundary is column 0.
- SCAN_U: probes along column xc, decrementing y. Image boundary is row 0.
- SCAN_D: probes along column xc, incrementing y. Image boundary is row HEIGHT-1.
- Centre pixel: never tested. If the centre pixel is background, the edges degenerate toward the centre (e.g. the neighbour is background, so the edge equals the centre coordinate).
- Edge registers: each edge register updates only when its scan finishes.
- edges_valid: pulses for one cycle on entry to CORNER, with all four edges stable.
- CORNER (one cycle):
  - corner_addr_out = top_edge*WIDTH + left_edge, 17-bit unsigned.
  - corner_width = (right_edge-left_edge)>>2 and corner_height = (bot_edge-top_edge)>>2, both unsigned and truncating.
  - corner_valid pulses on the cycle after edges_valid.
  - The FSM then returns to IDLE.
- Output hold: all result outputs hold until the next completed run or reset.
- Arithmetic: the address multiply may use a constant multiplier or a shift-add (240 = 256-16).

Test Plan:
- Image of 16'hFFFF for x 40..190, y 30..280, else 0; start with centre (114,153) -> right 190, left 40, top 30, bot 280; corner_addr 7240, corner_width 37, corner_height 62; edges_valid one cycle, then corner_valid the next cycle.
- Card filling the whole frame, centre (114,153) -> right 239, left 0, top 0, bot 319; no out-of-range address is ever issued (max 76799).
- Background centre with 0 neighbours at (10,10) -> all edges equal the centre coordinates (10,10,10,10); corner_width 0, corner_height 0, corner_addr 2410.
- Assert rst_in for one cycle during SCAN_U -> outputs zero next cycle, no valid pulse; a fresh start then gives the correct result.
- Second find_corners_flag pulse during SCAN_L -> ignored; exactly one edges_valid/corner_valid pair for the run.
- Address check during SCAN_R on the first image: the first probe address is 153*240+115 = 36835, and each new probe address is held READ_LATENCY+1 cycles.
